// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-subset main control FSM with memory-ready stalls and access timeout.
// Optional `ILLEGAL_TRAP_EN: unsupported opcodes trap instead of retiring as NOPs.
module mc_control_fsm #(
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic [1:0]         branch_op,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         mem_to_reg,
  output logic [1:0]         reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_source,
  output logic [3:0]         state_dbg,
  output logic               mem_err,
  output logic               illegal_op
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_EXEC_I   = 4'd3;
  localparam logic [3:0] S_MEM_ADDR = 4'd4;
  localparam logic [3:0] S_MEM_RD   = 4'd5;
  localparam logic [3:0] S_MEM_WB   = 4'd6;
  localparam logic [3:0] S_MEM_WR   = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_JUMP     = 4'd9;
  localparam logic [3:0] S_ALU_WB   = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [ALUOP_W-1:0] ALU_ADD = '0;
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_R   = ALUOP_W'(2);

  localparam logic       TIMEOUT_EN  = (MEM_TIMEOUT != 0);
  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  logic [3:0] state_reg, state_next;
  logic [7:0] wait_cnt_reg;
  logic       mem_err_reg;
  logic       wait_state;
  logic       timeout;

  assign wait_state = (state_reg == S_FETCH) || (state_reg == S_MEM_RD) || (state_reg == S_MEM_WR);
  // mem_ready on the expiry cycle completes the access rather than trapping.
  assign timeout    = TIMEOUT_EN && wait_state && !mem_ready && (wait_cnt_reg == TIMEOUT_CNT);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:    if (timeout) state_next = S_TRAP; else if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                        state_next = S_EXEC_R;
          OP_ADDI:                         state_next = S_EXEC_I;
          OP_LW, OP_SW:                    state_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: state_next = S_BRANCH;
          OP_J, OP_JAL:                    state_next = S_JUMP;
`ifdef ILLEGAL_TRAP_EN
          default:                         state_next = S_TRAP;
`else
          default:                         state_next = S_FETCH;
`endif
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_next = S_ALU_WB;
      S_MEM_ADDR: state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (timeout) state_next = S_TRAP; else if (mem_ready) state_next = S_MEM_WB;
      S_MEM_WR:   if (timeout) state_next = S_TRAP; else if (mem_ready) state_next = S_FETCH;
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP: state_next = S_FETCH;
      S_TRAP:     state_next = S_TRAP;
      default:    state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_FETCH;
      wait_cnt_reg <= '0;
      mem_err_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_next != state_reg)
        wait_cnt_reg <= '0;
      else if (wait_state && !mem_ready && wait_cnt_reg != 8'hFF)
        wait_cnt_reg <= wait_cnt_reg + 8'd1;
      if (timeout)
        mem_err_reg <= 1'b1;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_op_reg;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      illegal_op_reg <= 1'b0;
    else if (state_reg == S_DECODE && state_next == S_TRAP)
      illegal_op_reg <= 1'b1;
  end
  assign illegal_op = illegal_op_reg;
`else
  assign illegal_op = 1'b0;
`endif

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_op     = 2'd0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 2'd0;
    reg_dst       = 2'd0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = ALU_ADD;
    pc_source     = 2'd0;
    case (state_reg)
      S_FETCH: if (!timeout) begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = 2'd3;
      S_EXEC_R: begin alu_src_a = 1'b1; alu_op = ALU_R; end
      S_EXEC_I, S_MEM_ADDR: begin alu_src_a = 1'b1; alu_src_b = 2'd2; end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = (opcode == OP_RTYPE) ? 2'd1 : 2'd0;
      end
      S_MEM_RD: if (!timeout) begin mem_read = 1'b1; iord = 1'b1; end
      S_MEM_WR: if (!timeout) begin mem_write = 1'b1; iord = 1'b1; end
      S_MEM_WB: begin reg_write = 1'b1; mem_to_reg = 2'd1; end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'd1;
        case (opcode)
          OP_BNE:  branch_op = 2'd1;
          OP_BGTZ: branch_op = 2'd2;
          OP_BLEZ: branch_op = 2'd3;
          default: branch_op = 2'd0;
        endcase
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'd2;
        if (opcode == OP_JAL) begin
          reg_write  = 1'b1;
          reg_dst    = 2'd2;
          mem_to_reg = 2'd2;
        end
      end
      default: ;
    endcase
  end

  assign state_dbg = state_reg;
  assign mem_err   = mem_err_reg;

endmodule
